alu_seq_multiplier: RTL and testbench
=====================================

Name: alu_seq_multiplier

Overview:
- Iterative radix-2 shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
- Sits directly upstream of alu_carry_lookahead_adder: every cycle it drives the adder's operands and consumes its 32-bit sum to update the partial-product accumulator.
- Gives the RV32M extension without a combinational 32x32 array.
- Stalls the core through a valid/ready handshake.

Parameters:
- XLEN, 32, operand width; must equal the adder width, and only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > XLEN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block idle and able to accept a request.
- i_op  in  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU (funct3[1:0]).
- i_rs1  in  32  multiplicand operand.
- i_rs2  in  32  multiplier operand.
- i_flush  in  1  abort any operation in progress.
- o_valid  out  1  one-cycle result strobe.
- o_result  out  32  MUL gives the low 32 bits; all other ops give the high 32 bits.
- o_busy  out  1  operation in flight.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_result=0, accumulator=0, counter=0.
- Accept: on a rising edge with i_valid && o_ready && !i_flush.
  - Latch i_op, i_rs1, i_rs2.
  - o_ready drops in the next cycle.
- FSM states: IDLE -> ABS -> MUL -> FIX_LO -> FIX_HI -> DONE -> IDLE.
- ABS (1 cycle):
  - Take signed magnitudes: rs1 is signed for MULH and MULHSU; rs2 is signed for MULH only.
  - Record neg = sign(rs1) XOR sign(rs2), counting signed operands only.
  - Set acc_hi=0, acc_lo=|rs2|, counter=0.
- MUL (exactly 32 cycles):
  - Adder inputs are a=acc_hi and b=(acc_lo[0] ? |rs1| : 0).
  - carry = (a[31]&b[31]) | ((a[31]^b[31]) & ~sum[31]).
  - {acc_hi,acc_lo} <= {carry,sum,acc_lo} >> 1.
  - The counter increments each cycle; leave MUL when counter==31.
- FIX_LO / FIX_HI (1 cycle each):
  - If neg, negate the 64-bit accumulator: ~lo+1 through the adder in FIX_LO, then ~hi+carry in FIX_HI.
  - If not neg, both cycles hold the accumulator unchanged.
  - Latency is fixed regardless of sign.
- DONE (1 cycle):
  - o_valid=1 and o_result is driven.
  - Return to IDLE on the next edge.
  - o_result holds its value until the next DONE or reset.
- Latency: o_valid is high in the cycle after the 35th rising edge counted from the accepting edge.
- o_busy = (state != IDLE).
- o_ready = (state == IDLE).
- Flush:
  - i_flush in any non-IDLE state returns to IDLE on the next edge.
  - No o_valid is produced; o_result is unchanged.
  - i_flush and i_valid together in IDLE: flush wins and the request is not accepted.
- Reset asserted mid-operation: all state is cleared immediately and no o_valid is produced.
- i_valid while busy is ignored, because o_ready=0.
- Back-to-back: a new request may be accepted in the cycle following DONE.

Optional Feature:
- Macro: ALU_MUL_ZERO_BYPASS_EN.
- Defined: if i_rs1==0 or i_rs2==0 at accept, the FSM goes directly to DONE with result 0. o_valid is high in the cycle after the accepting edge, and the adder is not exercised.
- Undefined: zero operands take the full fixed latency like any other operands.

Decomposition:
- Shared package alu_pkg:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU).
  - mul_state_e enum.
  - XLEN constant.
  - MUL_ITER constant = 32.
- One sub-module: an instance of alu_carry_lookahead_adder, shared by the MUL iterations and the FIX negation through an operand mux.
- Carry reconstruction stays local to this block.

Test Plan:
- MUL, rs1=7, rs2=6 -> o_valid after the fixed latency, o_result=0x0000002A, and o_ready high again in the cycle after o_valid.
- MULHU, rs1=rs2=0xFFFFFFFF -> o_result=0xFFFFFFFE. The same operands with MUL -> 0x00000001.
- MULH, rs1=rs2=0x80000000 -> 0x40000000. MULH with -1 * -1 -> 0x00000000.
- MULHSU, rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF. MUL with the same operands -> 0x00000001.
- Flush and reset mid-operation:
  - Pulse i_flush 10 cycles after accept -> no o_valid, o_ready=1 on the next cycle, and a following MUL 3*5 returns 0x0000000F.
  - Assert i_rst_n=0 mid-operation -> all outputs return to their reset values immediately.
- Zero operand: MUL 0*0x12345678 -> 0. With ALU_MUL_ZERO_BYPASS_EN defined, o_valid comes one edge after accept; without it, o_valid comes at the full fixed latency.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared types and constants for the ALU blocks.
//   - XLEN      : datapath width (32 only)
//   - MUL_ITER  : number of shift-and-add iterations in the multiplier
//   - CNT_W     : iteration counter width (2**CNT_W > XLEN)
//   - mul_op_e  : RV32M multiply variant, encoded as funct3[1:0]
//   - mul_state_e : sequential multiplier FSM states
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN     = 32;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABS    = 3'd1,
        ST_MUL    = 3'd2,
        ST_FIX_LO = 3'd3,
        ST_FIX_HI = 3'd4,
        ST_DONE   = 3'd5
    } mul_state_e;

endpackage

// File: rtl/alu_carry_lookahead_adder.sv
// ----------------------------------------------------------------------------
// alu_carry_lookahead_adder
//   Combinational WIDTH-bit adder built from 4-bit carry-lookahead groups,
//   with group carries chained between groups. No carry-out is exported:
//   users that need it reconstruct it from the operand and sum MSBs.
//   Ports:
//     a, b  in  WIDTH  addends
//     cin   in  1      carry into bit 0
//     sum   out WIDTH  a + b + cin (modulo 2**WIDTH)
// ----------------------------------------------------------------------------
module alu_carry_lookahead_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    for (genvar k = 0; k < WIDTH / 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        // Carry into the next group; the top group's carry-out is not needed.
        if (k < WIDTH / 4 - 1) begin : g_next
            assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B])
                          | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/alu_seq_multiplier.sv
// ----------------------------------------------------------------------------
// alu_seq_multiplier
//   Iterative radix-2 shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
//   One shared alu_carry_lookahead_adder does every addition: the 32 MUL
//   iterations and the two-cycle 64-bit negation of the product.
//   Fixed latency: o_valid is high in the cycle after the 35th rising edge
//   counted from the accepting edge.
//
//   Handshake: a request is accepted on a rising edge where
//   i_valid && o_ready && !i_flush. o_ready is high only in IDLE, so i_valid
//   is ignored while an operation is in flight. o_valid is a one-cycle
//   strobe; o_result holds until the next result or reset. i_flush in any
//   non-IDLE state aborts to IDLE without a result.
//
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset
//     i_valid/o_ready  request handshake
//     i_op             00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//     i_rs1, i_rs2     multiplicand, multiplier
//     i_flush          abort
//     o_valid/o_result result strobe and value
//     o_busy           operation in flight
//     o_state          FSM state (debug visibility)
//
//   Optional build macro ALU_MUL_ZERO_BYPASS_EN: a zero operand at accept
//   skips straight to DONE with result 0, one edge after accept.
// ----------------------------------------------------------------------------
module alu_seq_multiplier
    import alu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy,
    output logic [2:0]      o_state
);

    mul_state_e       state;
    mul_op_e          op;
    logic [XLEN-1:0]  mcand;      // raw rs1 until ABS, then |rs1|
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;     // raw rs2 until ABS, then the shifting multiplier
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             fix_carry;  // carry from ~lo+1 into the high word

    logic             s1_neg;
    logic             s2_neg;
    logic [XLEN-1:0]  add_a;
    logic [XLEN-1:0]  add_b;
    logic             add_cin;
    logic [XLEN-1:0]  add_sum;
    logic             add_carry;

    // Sign of each operand, counted only when that operand is signed for op.
    assign s1_neg = mcand[XLEN-1]  & ((op == OP_MULH) || (op == OP_MULHSU));
    assign s2_neg = acc_lo[XLEN-1] & (op == OP_MULH);

    always_comb begin
        add_a   = acc_hi;
        add_b   = acc_lo[0] ? mcand : '0;
        add_cin = 1'b0;
        case (state)
            ST_FIX_LO: begin
                add_a   = ~acc_lo;
                add_b   = '0;
                add_cin = 1'b1;
            end
            ST_FIX_HI: begin
                add_a   = ~acc_hi;
                add_b   = '0;
                add_cin = fix_carry;
            end
            default: ;
        endcase
    end

    alu_carry_lookahead_adder #(.WIDTH(XLEN)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    // Carry-out recovered from MSBs: both set, or exactly one set and the
    // sum MSB cleared by a carry rippling through it.
    assign add_carry = (add_a[XLEN-1] & add_b[XLEN-1])
                     | ((add_a[XLEN-1] ^ add_b[XLEN-1]) & ~add_sum[XLEN-1]);

    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            op        <= OP_MUL;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            fix_carry <= 1'b0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_result  <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_flush && state != ST_IDLE) begin
                state   <= ST_IDLE;
                o_ready <= 1'b1;
                o_busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_valid && !i_flush) begin
                            op      <= mul_op_e'(i_op);
                            mcand   <= i_rs1;
                            acc_lo  <= i_rs2;
                            acc_hi  <= '0;
                            o_ready <= 1'b0;
                            o_busy  <= 1'b1;
`ifdef ALU_MUL_ZERO_BYPASS_EN
                            if (i_rs1 == '0 || i_rs2 == '0) begin
                                state    <= ST_DONE;
                                o_valid  <= 1'b1;
                                o_result <= '0;
                            end else begin
                                state <= ST_ABS;
                            end
`else
                            state <= ST_ABS;
`endif
                        end
                    end
                    ST_ABS: begin
                        mcand  <= s1_neg ? (~mcand + 1'b1) : mcand;
                        acc_lo <= s2_neg ? (~acc_lo + 1'b1) : acc_lo;
                        acc_hi <= '0;
                        neg    <= s1_neg ^ s2_neg;
                        cnt    <= '0;
                        state  <= ST_MUL;
                    end
                    ST_MUL: begin
                        // {acc_hi,acc_lo} <= {carry,sum,acc_lo} >> 1
                        acc_hi <= {add_carry, add_sum[XLEN-1:1]};
                        acc_lo <= {add_sum[0], acc_lo[XLEN-1:1]};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(MUL_ITER - 1)) begin
                            state <= ST_FIX_LO;
                        end
                    end
                    ST_FIX_LO: begin
                        if (neg) begin
                            acc_lo    <= add_sum;
                            fix_carry <= add_carry;
                        end
                        state <= ST_FIX_HI;
                    end
                    ST_FIX_HI: begin
                        if (neg) begin
                            acc_hi <= add_sum;
                        end
                        // acc_lo is already final; the high word is this cycle's sum when negating.
                        if (op == OP_MUL) begin
                            o_result <= acc_lo;
                        end else begin
                            o_result <= neg ? add_sum : acc_hi;
                        end
                        o_valid <= 1'b1;
                        state   <= ST_DONE;
                    end
                    ST_DONE: begin
                        state   <= ST_IDLE;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_multiplier
//   Scoreboard bench: the driver pushes the expected result and the expected
//   o_valid cycle on each request; a monitor pops and compares on o_valid.
//   Expected values come from a 64-bit arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_alu_seq_multiplier;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_busy;
    logic [2:0]  o_state;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          cyc;
    int          n_checks;
    int          n_errors;
    logic [31:0] last_result;
    logic        prev_valid;

    alu_seq_multiplier dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_busy   (o_busy),
        .o_state  (o_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int latency(input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MUL_ZERO_BYPASS_EN
        return (a == 0 || b == 0) ? 1 : 35;
`else
        if (a == b) return 35;  // keeps both operands referenced
        return 35;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            check("ready_timeout", {31'b0, o_ready}, 32'd1);
            return;
        end
        i_valid = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        exp_q.push_back(model(op, a, b));
        lat_q.push_back(cyc + 1 + latency(a, b));
        @(negedge clk);
        i_valid = 1'b0;
        i_op    = 2'($urandom_range(0, 3));
        i_rs1   = $urandom;
        i_rs2   = $urandom;
        check("ready_drop", {31'b0, o_ready}, 32'd0);
        check("busy_rise", {31'b0, o_busy}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid) begin
                check("ready_after_valid", {31'b0, o_ready}, 32'd1);
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'b0, o_valid}, 32'd0);
                end else begin
                    logic [31:0] e;
                    int          l;
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("result", o_result, e);
                    check("latency", 32'(cyc), 32'(l));
                    last_result = e;
                end
            end
            prev_valid = o_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_errors    = 0;
        last_result = '0;
        prev_valid  = 1'b0;
        rst_n       = 1'b0;
        i_valid     = 1'b0;
        i_flush     = 1'b0;
        i_op        = 2'b00;
        i_rs1       = '0;
        i_rs2       = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_state", {29'b0, o_state}, {29'b0, ST_IDLE});
        rst_n = 1'b1;

        // Directed cases
        issue(2'b00, 32'd7, 32'd6);
        drain();
        check("mul_7x6_const", last_result, 32'h0000_002A);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        check("mulhu_ones_const", last_result, 32'hFFFF_FFFE);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        drain();
        check("mulh_min_const", last_result, 32'h4000_0000);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        check("mulhsu_const", last_result, 32'hFFFF_FFFF);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b00, 32'h0000_0000, 32'h1234_5678);
        issue(2'b01, 32'h1234_5678, 32'h0000_0000);
        drain();

        // Flush 10 cycles after accept
        issue(2'b00, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        exp_q.delete();
        lat_q.delete();
        check("flush_ready", {31'b0, o_ready}, 32'd1);
        check("flush_busy", {31'b0, o_busy}, 32'd0);
        check("flush_result_hold", o_result, last_result);
        repeat (40) @(negedge clk);
        issue(2'b00, 32'd3, 32'd5);
        drain();
        check("after_flush_const", last_result, 32'h0000_000F);

        // Flush together with valid in IDLE: not accepted
        @(negedge clk);
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_op    = 2'b00;
        i_rs1   = 32'd9;
        i_rs2   = 32'd9;
        @(negedge clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("flush_wins_ready", {31'b0, o_ready}, 32'd1);
        check("flush_wins_busy", {31'b0, o_busy}, 32'd0);

        // Reset mid-operation
        issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        lat_q.delete();
        check("midrst_ready", {31'b0, o_ready}, 32'd1);
        check("midrst_valid", {31'b0, o_valid}, 32'd0);
        check("midrst_busy", {31'b0, o_busy}, 32'd0);
        check("midrst_result", o_result, 32'd0);
        check("midrst_state", {29'b0, o_state}, {29'b0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        last_result = '0;
        repeat (40) @(negedge clk);

        // Randomized stream, back-to-back where possible
        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand());
        end
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
